// File: rtl/clk_period_monitor.sv
// ---------------------------------------------------------------------------
// clk_period_monitor
//
// Measures the period of an externally toggled, clock-like signal in units of
// the system clock. The monitored signal is synchronised, its rising edges
// are detected, and each complete rise-to-rise period is reported with a
// one-cycle valid strobe. It also flags two faults:
//   - stuck:    the source produced no edge for MAX_PERIOD cycles;
//   - fast_err: the source produced a period shorter than MIN_PERIOD cycles.
//
// Ports:
//   clk      in   system clock; all logic runs on its rising edge
//   rst      in   asynchronous active-high reset
//   en       in   monitor enable (level); low returns the monitor to idle
//   mon_in   in   monitored signal, asynchronous to clk
//   period_o out  last measured period in clk cycles, held between updates
//   valid    out  one-cycle strobe, period_o updated this cycle
//   fast_err out  one-cycle strobe, coincident with valid, period < MIN_PERIOD
//   stuck    out  one-cycle strobe, MAX_PERIOD cycles with no rising edge
//   busy     out  high while waiting for the first edge or measuring
// ---------------------------------------------------------------------------
module clk_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  output logic [CNT_W-1:0] period_o,
  output logic             valid,
  output logic             fast_err,
  output logic             stuck,
  output logic             busy
);

  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(MIN_PERIOD);

  // S_ARM: waiting for the first edge, no reference point yet.
  // S_MEASURE: a reference edge has been seen, counting towards the next one.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_edge;
  logic             w_rise;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_next;
  logic             r_valid;
  logic             r_fast;
  logic             r_stuck;
  logic             r_busy;
  logic             w_valid_next;
  logic             w_fast_next;
  logic             w_stuck_next;

  // Rising edge of the synchronised input, one cycle wide.
  assign w_rise    = r_sync2 & ~r_edge;

  // The counter never exceeds MAX_PERIOD-1, so cnt+1 always fits in CNT_W
  // and equals the number of cycles elapsed since the last reference point.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == L_MAX);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_period_next = r_period;
    w_valid_next  = 1'b0;
    w_fast_next   = 1'b0;
    w_stuck_next  = 1'b0;

    if (!en) begin
      // Disabling always wins: any rise on this cycle is dropped.
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_ARM;
          w_cnt_next   = '0;
        end
        S_ARM: begin
          if (w_rise) begin
            w_state_next = S_MEASURE;
            w_cnt_next   = '0;
          end else if (w_timeout) begin
            w_stuck_next = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        S_MEASURE: begin
          // A rise on the timeout cycle is a legal period of MAX_PERIOD.
          if (w_rise) begin
            w_period_next = w_cnt_inc;
            w_valid_next  = 1'b1;
            w_fast_next   = (w_cnt_inc < L_MIN);
            w_cnt_next    = '0;
          end else if (w_timeout) begin
            w_stuck_next  = 1'b1;
            w_cnt_next    = '0;
            w_state_next  = S_ARM;
          end else begin
            w_cnt_next    = w_cnt_inc;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_edge   <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_fast   <= 1'b0;
      r_stuck  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sync1  <= mon_in;
      r_sync2  <= r_sync1;
      r_edge   <= r_sync2;
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_period <= w_period_next;
      r_valid  <= w_valid_next;
      r_fast   <= w_fast_next;
      r_stuck  <= w_stuck_next;
      // Registered copy of (state != IDLE), aligned with r_state.
      r_busy   <= (w_state_next != S_IDLE);
    end
  end

  assign period_o = r_period;
  assign valid    = r_valid;
  assign fast_err = r_fast;
  assign stuck    = r_stuck;
  assign busy     = r_busy;

endmodule

// File: tb/tb_clk_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_period_monitor
//
// Self-checking bench for clk_period_monitor. A reference model tracks the
// time elapsed since the last reference point (monitor start, rising edge or
// timeout) and derives the expected outputs every cycle. A table of fixed
// waveforms checks period/fault results, a few hand-written sequences cover
// timeout spacing, source stop/restart, async reset and disable, and a
// randomised phase stresses the whole thing against the model.
// ---------------------------------------------------------------------------
module tb_clk_period_monitor;

  localparam int CNT_W      = 16;
  localparam int MIN_PERIOD = 4;
  localparam int MAX_PERIOD = 1000;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mon_in;
  logic [CNT_W-1:0] period_o;
  logic             valid;
  logic             fast_err;
  logic             stuck;
  logic             busy;

  clk_period_monitor #(
    .CNT_W     (CNT_W),
    .MIN_PERIOD(MIN_PERIOD),
    .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mon_in  (mon_in),
    .period_o(period_o),
    .valid   (valid),
    .fast_err(fast_err),
    .stuck   (stuck),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model state.
  int cyc;
  bit h1, h2, h3;           // mon_in as sampled 1, 2, 3 edges ago
  bit m_active;             // monitor enabled and running
  bit m_meas;               // a reference edge exists
  int m_start;              // cycle of the last reference point
  int m_period;
  bit e_valid, e_fast, e_stuck;

  // Observed-event bookkeeping.
  int n_valid, n_fast, n_stuck;
  int stuck_q[$];

  // Waveform generator.
  bit g_level;
  int g_left;

  typedef struct {
    int hi;
    int lo;
    int ncyc;
    int exp_period;
    bit exp_fast;
    bit exp_stuck;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d act %0d exp %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    h1 = 0; h2 = 0; h3 = 0;
    m_active = 0; m_meas = 0; m_start = 0; m_period = 0;
    e_valid = 0; e_fast = 0; e_stuck = 0;
  endtask

  // Applied at each rising clk edge with the inputs the DUT just sampled.
  task automatic model_update();
    bit rise;
    int el;
    // An edge of mon_in becomes a rise after two synchroniser stages.
    rise = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = mon_in;
    e_valid = 0; e_fast = 0; e_stuck = 0;
    if (!en) begin
      m_active = 0;
      m_meas   = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_meas   = 0;
      m_start  = cyc;
    end else begin
      el = cyc - m_start;
      if (rise) begin
        if (m_meas) begin
          m_period = el;
          e_valid  = 1;
          e_fast   = (el < MIN_PERIOD);
        end
        m_meas  = 1;
        m_start = cyc;
      end else if (el == MAX_PERIOD) begin
        e_stuck = 1;
        m_meas  = 0;
        m_start = cyc;
      end
    end
  endtask

  // One clock: update model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_update();
    @(negedge clk);
    check("period_o", int'(period_o), m_period);
    check("valid",    int'(valid),    int'(e_valid));
    check("fast_err", int'(fast_err), int'(e_fast));
    check("stuck",    int'(stuck),    int'(e_stuck));
    check("busy",     int'(busy),     int'(m_active));
    n_valid += int'(valid);
    n_fast  += int'(fast_err);
    n_stuck += int'(stuck);
    if (stuck) stuck_q.push_back(cyc);
  endtask

  // Run n cycles of a waveform that is high for hi cycles and low for lo.
  task automatic drive_cycles(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      step();
      g_left--;
      if (g_left <= 0) begin
        g_level = ~g_level;
        g_left  = g_level ? hi : lo;
        mon_in  = g_level;
      end
    end
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    n_valid = 0; n_fast = 0; n_stuck = 0;
    stuck_q.delete();
  endtask

  // Called at a falling edge; leaves the DUT idle, out of reset, en=0.
  task automatic do_reset();
    rst = 1; en = 0; mon_in = 0;
    g_level = 0;
    step();
    step();
    rst = 0;
  endtask

  int base;
  int hi_r, lo_r, n_r;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1; en = 0; mon_in = 0;
    model_reset();
    clear_counts();

    vecs[0] = '{hi: 10,  lo: 10,  ncyc: 200,  exp_period: 20,   exp_fast: 1'b0, exp_stuck: 1'b0};
    vecs[1] = '{hi: 1,   lo: 1,   ncyc: 60,   exp_period: 2,    exp_fast: 1'b1, exp_stuck: 1'b0};
    vecs[2] = '{hi: 2,   lo: 1,   ncyc: 60,   exp_period: 3,    exp_fast: 1'b1, exp_stuck: 1'b0};
    vecs[3] = '{hi: 2,   lo: 2,   ncyc: 60,   exp_period: 4,    exp_fast: 1'b0, exp_stuck: 1'b0};
    vecs[4] = '{hi: 500, lo: 500, ncyc: 2600, exp_period: 1000, exp_fast: 1'b0, exp_stuck: 1'b0};
    vecs[5] = '{hi: 499, lo: 500, ncyc: 2600, exp_period: 999,  exp_fast: 1'b0, exp_stuck: 1'b0};
    vecs[6] = '{hi: 501, lo: 500, ncyc: 3000, exp_period: 0,    exp_fast: 1'b0, exp_stuck: 1'b1};

    @(negedge clk);
    do_reset();

    // Table-driven waveforms.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      clear_counts();
      g_level = 0;
      g_left  = vecs[v].lo;
      en = 1;
      drive_cycles(vecs[v].ncyc, vecs[v].hi, vecs[v].lo);
      check($sformatf("vec%0d_period", v), int'(period_o), vecs[v].exp_period);
      check($sformatf("vec%0d_fast_seen", v), int'(n_fast > 0), int'(vecs[v].exp_fast));
      check($sformatf("vec%0d_stuck_seen", v), int'(n_stuck > 0), int'(vecs[v].exp_stuck));
      check($sformatf("vec%0d_valid_seen", v), int'(n_valid > 0), int'(vecs[v].exp_period != 0));
    end

    // Source held low: timeouts at ARM entry + 1000, then every 1000.
    do_reset();
    clear_counts();
    base = cyc;
    en = 1;
    hold_cycles(2100);
    check("hold_stuck_count", stuck_q.size(), 2);
    check("hold_stuck_first",  (stuck_q.size() > 0) ? stuck_q[0] - base : -1, 1001);
    check("hold_stuck_second", (stuck_q.size() > 1) ? stuck_q[1] - base : -1, 2001);
    check("hold_valid_count", n_valid, 0);

    // Source stops mid-measurement, then restarts.
    do_reset();
    clear_counts();
    g_level = 0; g_left = 10;
    en = 1;
    drive_cycles(200, 10, 10);
    clear_counts();
    hold_cycles(1100);
    check("stop_stuck_count", n_stuck, 1);
    check("stop_valid_count", n_valid, 0);
    check("stop_period_kept", int'(period_o), 20);
    check("stop_busy", int'(busy), 1);
    clear_counts();
    drive_cycles(100, 10, 10);
    check("restart_period", int'(period_o), 20);
    check("restart_valid_seen", int'(n_valid > 0), 1);

    // Disable during MEASURE: idle next cycle, period retained.
    en = 0;
    step();
    check("dis_busy", int'(busy), 0);
    check("dis_period_kept", int'(period_o), 20);
    hold_cycles(5);
    en = 1;
    drive_cycles(100, 10, 10);

    // Asynchronous reset between clock edges clears outputs at once.
    #2;
    rst = 1;
    #1;
    check("arst_period", int'(period_o), 0);
    check("arst_valid",  int'(valid),    0);
    check("arst_fast",   int'(fast_err), 0);
    check("arst_stuck",  int'(stuck),    0);
    check("arst_busy",   int'(busy),     0);
    step();
    en = 0; mon_in = 0; g_level = 0;
    step();
    rst = 0;
    hold_cycles(3);
    en = 1;
    g_left = 7;
    drive_cycles(150, 7, 7);
    check("post_rst_period", int'(period_o), 14);

    // Randomised segments against the reference model.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        hi_r = $urandom_range(495, 505);
        lo_r = $urandom_range(495, 505);
        n_r  = 2500;
      end else begin
        hi_r = $urandom_range(1, 15);
        lo_r = $urandom_range(1, 15);
        n_r  = $urandom_range(20, 400);
      end
      if ($urandom_range(0, 7) == 0) begin
        en = 0;
        drive_cycles($urandom_range(1, 6), hi_r, lo_r);
        en = 1;
      end
      drive_cycles(n_r, hi_r, lo_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
